// File: rtl/bcache_assoc_if.sv
// Fetch lookup, execute update and flush signals of the branch target cache.
interface bcache_assoc_if #(
    parameter int unsigned addr_width = 12
);
    logic [addr_width-1:0] addr;
    logic                  taken;
    logic                  not_taken;
    logic [addr_width-1:0] pc;
    logic [addr_width-1:0] jump_vec;
    logic                  flush;
    logic                  flush_busy;
    logic                  predict_hit;
    logic                  predict_taken;
    logic [addr_width-1:0] predict_target;

    modport master (
        output addr, taken, not_taken, pc, jump_vec, flush,
        input  flush_busy, predict_hit, predict_taken, predict_target
    );

    modport slave (
        input  addr, taken, not_taken, pc, jump_vec, flush,
        output flush_busy, predict_hit, predict_taken, predict_target
    );
endinterface

// File: rtl/bcache_assoc.sv
// N-way set-associative branch target cache with saturating counters,
// per-set round-robin replacement and a one-set-per-cycle flush sequencer.
module bcache_assoc #(
    parameter int unsigned addr_width    = 12,
    parameter int unsigned sets          = 4,
    parameter int unsigned ways          = 2,
    parameter int unsigned counter_width = 2
) (
    input logic           clk,
    input logic           reset,
    bcache_assoc_if.slave bus
);
    localparam int unsigned aw = addr_width;
    localparam int unsigned cw = counter_width;
    localparam int unsigned iw = $clog2(sets);
    localparam int unsigned tw = addr_width - iw;
    localparam int unsigned ww = (ways > 1) ? $clog2(ways) : 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t        state;
    state_t        state_next;
    logic [iw-1:0] flush_set;
    logic          busy_c;
    logic          upd_en_c;

    logic [sets-1:0][ways-1:0]         valid;
    logic [sets-1:0][ways-1:0][tw-1:0] tag;
    logic [sets-1:0][ways-1:0][cw-1:0] ctr;
    logic [sets-1:0][ways-1:0][aw-1:0] target;
    logic [sets-1:0][ww-1:0]           rr_ptr;

    logic [iw-1:0]   l_idx;
    logic [tw-1:0]   l_tag;
    logic [ways-1:0] l_match;
    logic            l_hit;
    logic [ww-1:0]   l_way;

    logic [iw-1:0]   u_idx;
    logic [tw-1:0]   u_tag;
    logic [ways-1:0] u_match;
    logic            u_hit;
    logic [ww-1:0]   u_way;
    logic [ww-1:0]   victim;
    logic            any_inv;
    logic [ww-1:0]   rr_next;
    logic [cw-1:0]   u_ctr;
    logic [cw-1:0]   ctr_inc;
    logic [cw-1:0]   ctr_dec;

    assign l_idx = bus.addr[iw-1:0];
    assign l_tag = bus.addr[aw-1:iw];
    assign u_idx = bus.pc[iw-1:0];
    assign u_tag = bus.pc[aw-1:iw];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.flush) state_next = FLUSH;
            FLUSH:   if (flush_set == iw'(sets - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_c   = 1'b0;
        upd_en_c = 1'b0;
        case (state)
            IDLE:    upd_en_c = bus.taken || bus.not_taken;
            FLUSH:   busy_c   = 1'b1;
            default: busy_c   = 1'b0;
        endcase
    end

    assign bus.flush_busy = busy_c;

    // sets is a power of two, so the walk wraps back to 0 on its own
    always_ff @(posedge clk) begin
        if (reset)       flush_set <= '0;
        else if (busy_c) flush_set <= flush_set + iw'(1);
    end

    // Tag match on both ports; at most one way may match
    always_comb begin
        l_match = '0;
        l_hit   = 1'b0;
        l_way   = '0;
        u_match = '0;
        u_hit   = 1'b0;
        u_way   = '0;
        for (int unsigned w = 0; w < ways; w++) begin
            l_match[ww'(w)] = valid[l_idx][ww'(w)] && (tag[l_idx][ww'(w)] == l_tag);
            u_match[ww'(w)] = valid[u_idx][ww'(w)] && (tag[u_idx][ww'(w)] == u_tag);
            if (l_match[ww'(w)]) begin
                l_hit = 1'b1;
                l_way = ww'(w);
            end
            if (u_match[ww'(w)]) begin
                u_hit = 1'b1;
                u_way = ww'(w);
            end
        end
    end

    always_comb begin
        victim  = rr_ptr[u_idx];
        any_inv = 1'b0;
        for (int unsigned w = 0; w < ways; w++) begin
            if (!valid[u_idx][ww'(w)] && !any_inv) begin
                victim  = ww'(w);
                any_inv = 1'b1;
            end
        end
        rr_next = (rr_ptr[u_idx] == ww'(ways - 1)) ? '0 : rr_ptr[u_idx] + ww'(1);
        u_ctr   = ctr[u_idx][u_way];
        ctr_inc = (u_ctr == '1) ? u_ctr : u_ctr + cw'(1);
        ctr_dec = (u_ctr == '0) ? u_ctr : u_ctr - cw'(1);
    end

    // Lookup reads the array as it stood before this edge's update
    always_ff @(posedge clk) begin
        if (reset || busy_c) begin
            bus.predict_hit    <= 1'b0;
            bus.predict_taken  <= 1'b0;
            bus.predict_target <= '0;
        end else begin
            bus.predict_hit    <= l_hit;
            bus.predict_taken  <= l_hit && ctr[l_idx][l_way][cw-1];
            bus.predict_target <= l_hit ? target[l_idx][l_way] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid  <= '0;
            tag    <= '0;
            ctr    <= '0;
            target <= '0;
            rr_ptr <= '0;
        end else if (busy_c) begin
            valid[flush_set]  <= '0;
            rr_ptr[flush_set] <= '0;
        end else if (upd_en_c) begin
            if (u_hit) begin
                if (bus.taken) begin
                    ctr[u_idx][u_way]    <= ctr_inc;
                    target[u_idx][u_way] <= bus.jump_vec;
                end else begin
                    ctr[u_idx][u_way]    <= ctr_dec;
                    target[u_idx][u_way] <= bus.pc + aw'(1);
                end
            end else if (bus.taken) begin
                valid[u_idx][victim]  <= 1'b1;
                tag[u_idx][victim]    <= u_tag;
                ctr[u_idx][victim]    <= '1;
                target[u_idx][victim] <= bus.jump_vec;
                if (!any_inv) rr_ptr[u_idx] <= rr_next;
            end
        end
    end

    a_excl_dir: assert property (@(posedge clk) disable iff (reset) !(bus.taken && bus.not_taken));
    a_l_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(l_match));
    a_u_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(u_match));
endmodule
